// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load-unit writebacks onto a
// single registered write port. ALU requests that cannot be written at once
// wait in a 2-entry in-order FIFO; a starvation counter forces the FIFO head
// through after the load unit has won four consecutive contended cycles.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        RegWEn,
    output logic [4:0]  rd,
    output logic [31:0] wr_data,
    output logic [31:0] busy_mask
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_HEAD,
        GNT_LOAD,
        GNT_BYPASS
    } grant_e;

    // FIFO storage: entry 0 is always the head (shift-register organisation)
    logic [4:0]  ent0_rd_q,   ent0_rd_d,   ent1_rd_q,   ent1_rd_d;
    logic [31:0] ent0_data_q, ent0_data_d, ent1_data_q, ent1_data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;

    logic        regwen_q, regwen_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wr_data_q, wr_data_d;

    grant_e      grant;
    logic        force_head;
    logic        fifo_ne;
    logic        alu_acc;
    logic        enq;
    logic        deq;
    logic [1:0]  occ;

    assign force_head = (starve_cnt_q == 3'd4);
    assign fifo_ne    = (cnt_q != 2'd0);
    assign alu_ready  = (cnt_q < 2'd2);
    assign ld_ready   = ~force_head;
    assign alu_acc    = alu_valid && alu_ready;

    assign RegWEn  = regwen_q;
    assign rd      = rd_q;
    assign wr_data = wr_data_q;

    // Grant selection: forced head, then load, then queued ALU, then bypass
    always_comb begin
        grant = GNT_NONE;
        if (force_head && fifo_ne)  grant = GNT_HEAD;
        else if (ld_valid)          grant = GNT_LOAD;
        else if (fifo_ne)           grant = GNT_HEAD;
        else if (alu_valid)         grant = GNT_BYPASS;
    end

    assign deq = (grant == GNT_HEAD);
    assign enq = alu_acc && (grant != GNT_BYPASS);
    assign occ = cnt_q - {1'b0, deq};

    // FIFO next state: shift on dequeue, then append into the first free slot
    always_comb begin
        ent0_rd_d   = ent0_rd_q;
        ent0_data_d = ent0_data_q;
        ent1_rd_d   = ent1_rd_q;
        ent1_data_d = ent1_data_q;
        if (deq) begin
            ent0_rd_d   = ent1_rd_q;
            ent0_data_d = ent1_data_q;
        end
        if (enq) begin
            if (occ == 2'd0) begin
                ent0_rd_d   = alu_rd;
                ent0_data_d = alu_data;
            end else begin
                ent1_rd_d   = alu_rd;
                ent1_data_d = alu_data;
            end
        end
        cnt_d = occ + {1'b0, enq};
    end

    // Starvation counter: count load wins over a waiting FIFO, clear otherwise
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (deq || !fifo_ne)
            starve_cnt_d = 3'd0;
        else if (grant == GNT_LOAD && starve_cnt_q != 3'd4)
            starve_cnt_d = starve_cnt_q + 3'd1;
    end

    // Write-port next state: rd==0 goes through the handshake but never writes
    always_comb begin
        regwen_d  = 1'b0;
        rd_d      = rd_q;
        wr_data_d = wr_data_q;
        case (grant)
            GNT_HEAD: begin
                rd_d      = ent0_rd_q;
                wr_data_d = ent0_data_q;
                regwen_d  = (ent0_rd_q != 5'd0);
            end
            GNT_LOAD: begin
                rd_d      = ld_rd;
                wr_data_d = ld_data;
                regwen_d  = (ld_rd != 5'd0);
            end
            GNT_BYPASS: begin
                rd_d      = alu_rd;
                wr_data_d = alu_data;
                regwen_d  = (alu_rd != 5'd0);
            end
            default: ;
        endcase
    end

    // Busy mask: destinations of entries still waiting in the FIFO, x0 excluded
    always_comb begin
        busy_mask = 32'd0;
        if (cnt_q >= 2'd1) busy_mask = busy_mask | (32'd1 << ent0_rd_q);
        if (cnt_q == 2'd2) busy_mask = busy_mask | (32'd1 << ent1_rd_q);
        busy_mask[0] = 1'b0;
    end

    // Control and write-port registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            starve_cnt_q <= 3'd0;
            regwen_q     <= 1'b0;
            rd_q         <= 5'd0;
            wr_data_q    <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            starve_cnt_q <= starve_cnt_d;
            regwen_q     <= regwen_d;
            rd_q         <= rd_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // FIFO payload storage; only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        ent0_rd_q   <= ent0_rd_d;
        ent0_data_q <= ent0_data_d;
        ent1_rd_q   <= ent1_rd_d;
        ent1_data_q <= ent1_data_d;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports alu_valid  input  1, alu_rd  input  5, alu_data  input  32  ALU writeback request.
REQ-004 SHALL have port alu_ready  output  1  ALU request accepted when alu_valid && alu_ready at posedge.
REQ-005 SHALL have ports ld_valid  input  1, ld_rd  input  5, ld_data  input  32  load-unit writeback request.
REQ-006 SHALL have port ld_ready  output  1  load request accepted when ld_valid && ld_ready at posedge.
REQ-007 SHALL have ports RegWEn  output  1, rd  output  5, wr_data  output  32  registered register-file write port.
REQ-008 SHALL have port busy_mask  output  32  bit n set while a write to xn is accepted but not yet presented on the write port.

Function
REQ-009 SHALL contain a 2-entry in-order FIFO (ALU requests only) plus a 3-bit starvation counter starve_cnt.
REQ-010 SHALL drive alu_ready = (FIFO count < 2), from registered state only, never from any valid input.
REQ-011 SHALL drive ld_ready = ~force, where force = (starve_cnt == 4).
REQ-012 SHALL select at most one grant per cycle, priority: force -> FIFO head; else ld_valid -> load; else FIFO non-empty -> FIFO head; else alu_valid -> ALU bypass.
REQ-013 SHALL enqueue an accepted ALU request not granted by bypass in the same cycle; enqueue and dequeue in the same cycle SHALL both take effect.
REQ-014 SHALL on a grant register RegWEn <= (granted rd != 0), rd <= granted rd, wr_data <= granted data; latency accept-to-RegWEn = 1 cycle (bypass/load), FIFO entries when granted.
REQ-015 SHALL on a cycle with no grant register RegWEn <= 0 and hold rd and wr_data.
REQ-016 SHALL treat rd == 0 requests as normal handshakes (accepted, queued, granted) but never assert RegWEn for them.
REQ-017 SHALL increment starve_cnt (saturating at 4) each cycle the FIFO is non-empty and the load is granted; SHALL clear it when the FIFO head is granted or the FIFO is empty.
REQ-018 SHALL preserve ALU request order; ordering between ALU and load writes is not guaranteed and is the issuer's responsibility via busy_mask.
REQ-019 SHALL form busy_mask as OR of one-hot(rd) over valid FIFO entries, with bit 0 forced to 0; combinational from registered state.
REQ-020 SHALL never overflow or underflow the FIFO; alu_valid with alu_ready=0 SHALL leave state unchanged for that request.

Reset
REQ-021 SHALL on rst_n=0, immediately and regardless of clk: RegWEn=0, rd=0, wr_data=0, FIFO empty, starve_cnt=0, hence alu_ready=1, ld_ready=1, busy_mask=0.
REQ-022 SHALL discard queued and in-flight requests on reset mid-operation; no write port activity until a new request after rst_n=1.

Verification
REQ-023 SHALL pass: idle, alu_valid=1 rd=5 data=0xDEADBEEF one cycle -> next cycle RegWEn=1 rd=5 wr_data=0xDEADBEEF; following cycle RegWEn=0.
REQ-024 SHALL pass: same cycle alu(rd=3,0x11) and ld(rd=7,0x22) -> cycle+1 write x7=0x22, busy_mask=0x8; cycle+2 write x3=0x11, busy_mask=0.
REQ-025 SHALL pass: ld_valid held 1 while ALU queued rd=9 -> four load writes, then ld_ready=0 for one cycle and x9 written, then ld_ready=1.
REQ-026 SHALL pass: ld_valid held 1, three ALU requests back-to-back -> alu_ready=0 after second is queued; third accepted only after a FIFO dequeue; writes in ALU order.
REQ-027 SHALL pass: alu(rd=0,0xFFFF) -> alu_ready handshake completes, RegWEn stays 0, busy_mask stays 0.
REQ-028 SHALL pass: rst_n pulsed low between clock edges with 2 entries queued -> outputs zero immediately, alu_ready=1, no queued write appears after release.
